mac_accumulator: RTL and testbench

Accumulation stage of the multi-bit MAC, directly downstream of the radix-4 Booth multiplier. Consumes the signed OUT_WIDTH-bit products through a valid/ready handshake and sums a programmed number of them into a wider signed accumulator with saturation. Presents the finished dot product on a held valid/ready output port.

---
 rtl/mac_pkg.sv | 17 +
 rtl/sat_add.sv | 28 ++
 rtl/mac_accumulator.sv | 103 ++++++++++
 tb/tb_mac_accumulator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: default widths used by the
// multiplier, the accumulation stage and the top-level MAC, plus the
// accumulator FSM state encoding.
package mac_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int OUT_WIDTH  = 32;
  localparam int ACC_WIDTH  = 40;
  localparam int LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the representable range of
// WIDTH bits and flags when clamping happened.
module sat_add #(
  parameter int WIDTH = mac_pkg::ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             sat_o
);

  // One guard bit is enough: the sum of two WIDTH-bit values fits in WIDTH+1.
  logic [WIDTH:0] full;

  assign full = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};

  // Overflow shows as disagreement between the guard bit and the sign bit;
  // the guard bit carries the true sign, selecting which rail to clamp to.
  always_comb begin
    sum_o = full[WIDTH-1:0];
    sat_o = 1'b0;
    if (full[WIDTH] != full[WIDTH-1]) begin
      sat_o = 1'b1;
      sum_o = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulation stage behind the Booth multiplier: sums a programmed number
// of signed products into a saturating accumulator and holds the result
// on a valid/ready port until it is taken.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result of the previous dot product stays visible
// ACCUM | accepting products, cnt = products still to come
// HOLD  | result presented on acc_valid until acc_ready
module mac_accumulator #(
  parameter int OUT_WIDTH = mac_pkg::OUT_WIDTH,
  parameter int ACC_WIDTH = mac_pkg::ACC_WIDTH,
  parameter int LEN_WIDTH = mac_pkg::LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 prod_valid,
  input  logic [OUT_WIDTH-1:0] prod,
  output logic                 prod_ready,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 sat,
  output logic                 busy
);
  import mac_pkg::*;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;

  logic signed [OUT_WIDTH-1:0] prod_s;
  logic [ACC_WIDTH-1:0]        prod_ext;
  logic [ACC_WIDTH-1:0]        add_sum;
  logic                        add_sat;

  assign prod_s   = prod;
  assign prod_ext = ACC_WIDTH'(prod_s);

  sat_add #(.WIDTH(ACC_WIDTH)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  // State, counter and result registers; reset aborts any dot product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state, accumulate and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = len;
          state_d = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          acc_d = add_sum;
          sat_d = sat_q | add_sat;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        acc_valid = 1'b1;
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == ACCUM) || (state_q == HOLD);
  assign acc_out = acc_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (default width and a narrow
// 34-bit accumulator) share stimulus; expected results are queued at
// issue time and popped by a monitor whenever a result is presented.
module tb_mac_accumulator;
  localparam int OW  = 32;
  localparam int LW  = 8;
  localparam int AW  = 40;
  localparam int AWS = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          prod_valid = 1'b0;
  logic [OW-1:0] prod = '0;
  logic          acc_ready = 1'b1;

  logic           prod_ready, acc_valid, sat, busy;
  logic [AW-1:0]  acc_out;
  logic           prod_ready_s, acc_valid_s, sat_s, busy_s;
  logic [AWS-1:0] acc_out_s;

  always #5 clk = ~clk;

  mac_accumulator #(.OUT_WIDTH(OW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out),
    .sat(sat), .busy(busy)
  );

  mac_accumulator #(.OUT_WIDTH(OW), .ACC_WIDTH(AWS), .LEN_WIDTH(LW)) dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_s),
    .acc_valid(acc_valid_s), .acc_ready(acc_ready), .acc_out(acc_out_s),
    .sat(sat_s), .busy(busy_s)
  );

  typedef struct {
    longint acc;
    bit     sat;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  int   prods[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: running sum clamped to the w-bit signed range after every add.
  function automatic exp_t model(input int w);
    longint hi, lo, a;
    exp_t   e;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    a = 0;
    e.sat = 1'b0;
    foreach (prods[i]) begin
      a = a + longint'(prods[i]);
      if (a > hi) begin a = hi; e.sat = 1'b1; end
      else if (a < lo) begin a = lo; e.sat = 1'b1; end
    end
    e.acc = a;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented result is compared with the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid) begin
        checks++;
        if (q_w.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid_w: acc_out %0d with no result pending", $signed(acc_out));
        end else begin
          if (longint'($signed(acc_out)) != q_w[0].acc || sat != q_w[0].sat) begin
            errors++;
            $display("FAIL result_w: got %0d sat %0b expected %0d sat %0b", $signed(acc_out), sat, q_w[0].acc, q_w[0].sat);
          end
          if (acc_ready) void'(q_w.pop_front());
        end
      end
      if (acc_valid_s) begin
        checks++;
        if (q_s.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid_s: acc_out %0d with no result pending", $signed(acc_out_s));
        end else begin
          if (longint'($signed(acc_out_s)) != q_s[0].acc || sat_s != q_s[0].sat) begin
            errors++;
            $display("FAIL result_s: got %0d sat %0b expected %0d sat %0b", $signed(acc_out_s), sat_s, q_s[0].acc, q_s[0].sat);
          end
          if (acc_ready) void'(q_s.pop_front());
        end
      end
      if (acc_valid && prod_ready) begin
        checks++;
        errors++;
        $display("FAIL ready_in_hold: prod_ready 1 while acc_valid 1");
      end
    end
  end

  // One dot product of n products from prods; optional stall before product
  // stall_at and hold_low cycles of backpressure on the result.
  task automatic run_dot(input int n, input int stall_at, input int stall_len,
                         input int hold_low, input bit push);
    int k;
    if (push) begin
      q_w.push_back(model(AW));
      q_s.push_back(model(AWS));
    end
    if (hold_low > 0) acc_ready = 1'b0;
    start = 1'b1;
    len   = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = LW'($urandom);
    if (n == 0) begin
      check("len0_valid_next_cycle", acc_valid, 1);
    end else begin
      check("ready_after_start", prod_ready, 1);
      for (int i = 0; i < n; i++) begin
        if (i == stall_at) begin
          prod_valid = 1'b0;
          repeat (stall_len) begin @(posedge clk); #1; end
          check("stall_ready_held", prod_ready, 1);
        end
        prod_valid = 1'b1;
        prod       = prods[i];
        @(posedge clk); #1;
        if (i < n - 1) check("no_early_valid", acc_valid, 0);
      end
      check("valid_after_last", acc_valid, 1);
    end
    prod_valid = 1'b1;
    prod       = $urandom;
    repeat (hold_low) begin
      @(negedge clk);
      check("hold_no_prod_ready", prod_ready, 0);
      @(posedge clk); #1;
    end
    acc_ready = 1'b1;
    k = 0;
    while (!(acc_valid && acc_ready) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) check("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    check("idle_after_handshake", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, sl, hl;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_acc_out", longint'(acc_out), 0);
    check("reset_sat", sat, 0);
    check("reset_prod_ready", prod_ready, 0);
    check("reset_acc_valid", acc_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_busy_s", busy_s, 0);
    @(posedge clk); #1;

    prods = '{75, 290, 35, -6, -36, 4};
    run_dot(6, -1, 0, 0, 1'b1);
    check("mixed_acc_out", longint'($signed(acc_out)), 362);
    check("mixed_sat", sat, 0);

    run_dot(6, 2, 3, 0, 1'b1);
    check("stall_acc_out", longint'($signed(acc_out)), 362);

    run_dot(6, -1, 0, 10, 1'b1);
    check("backpressure_acc_out", longint'($signed(acc_out)), 362);

    prods.delete();
    run_dot(0, -1, 0, 0, 1'b1);
    check("len0_acc_out", longint'($signed(acc_out)), 0);
    check("len0_sat", sat, 0);

    prods = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    run_dot(5, -1, 0, 0, 1'b1);
    check("sat34_acc_out", longint'(acc_out_s), 64'h1_FFFF_FFFF);
    check("sat34_flag", sat_s, 1);
    check("sat40_no_clamp", longint'($signed(acc_out)), 64'd10737418235);
    prods = '{1};
    run_dot(1, -1, 0, 0, 1'b1);
    check("after_sat_acc_out", longint'($signed(acc_out_s)), 1);
    check("after_sat_flag", sat_s, 0);

    prods = '{10, 20, 30, 40, 50, 60};
    start = 1'b1;
    len   = LW'(6);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1;
      prod       = prods[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prod_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_acc_valid", acc_valid, 0);
    check("abort_prod_ready", prod_ready, 0);
    check("abort_acc_out", longint'(acc_out), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_still_idle", acc_valid, 0);
    prods = '{-6};
    run_dot(1, -1, 0, 0, 1'b1);
    check("post_abort_acc_out", longint'($signed(acc_out)), -6);

    for (int t = 0; t < 30; t++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      prods.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) prods.push_back(int'($urandom));
        else prods.push_back(int'($urandom_range(0, 2000)) - 1000);
      end
      st = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      sl = int'($urandom_range(1, 4));
      hl = int'($urandom_range(0, 3));
      run_dot(n, st, sl, hl, 1'b1);
    end

    prods.delete();
    for (int i = 0; i < 255; i++) prods.push_back(int'($urandom_range(32'h4000_0000, 32'h7FFF_FFFF)));
    run_dot(255, 100, 2, 1, 1'b1);

    repeat (3) begin @(posedge clk); #1; end
    check("queue_w_drained", q_w.size(), 0);
    check("queue_s_drained", q_s.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
